// File: rtl/switch_pkg.sv
// Shared definitions for switch input conditioning: FSM state encodings and counter sizing.
package switch_pkg;

  typedef enum logic [1:0] {
    S_RELEASED     = 2'd0,
    S_PRESS_WAIT   = 2'd1,
    S_PRESSED      = 2'd2,
    S_RELEASE_WAIT = 2'd3
  } sw_state_t;

  // Wide enough to hold the larger of the two terminal counts without wrapping.
  function automatic int cnt_width(input int debounce_cyc, input int long_cyc);
    int m;
    m = (debounce_cyc > long_cyc) ? debounce_cyc : long_cyc;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/signal_sync.sv
// Generic STAGES-deep synchroniser for an asynchronous single-bit pin input.
module signal_sync #(
  parameter int STAGES = 2
) (
  input  logic clk_in,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] chain;

  always_ff @(posedge clk_in) begin
    if (rst) chain <= '0;
    else     chain <= {chain[STAGES-2:0], d};
  end

  assign q = chain[STAGES-1];

endmodule

// File: rtl/switch_debounce.sv
// Debounces one raw switch: clean level, press/release pulses, press count.
// Optional long-press detection is built when SWITCH_LONG_PRESS_EN is defined.
module switch_debounce
  import switch_pkg::*;
#(
  parameter int SYNC_STAGES  = 2,
  parameter int DEBOUNCE_CYC = 1_000_000,
  parameter int LONG_CYC     = 50_000_000,
  parameter int COUNT_W      = 16
) (
  input  logic               clk_in,
  input  logic               rst,
  input  logic               switch_raw,
  output logic               switch_level,
  output logic               press_pulse,
  output logic               release_pulse,
  output logic               long_pulse,
  output logic [COUNT_W-1:0] press_count
);

  localparam int CW = cnt_width(DEBOUNCE_CYC, LONG_CYC);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYC - 1);

  logic          sync;
  sw_state_t     state;
  logic [CW-1:0] cnt;

  signal_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk_in (clk_in),
    .rst    (rst),
    .d      (switch_raw),
    .q      (sync)
  );

  always_ff @(posedge clk_in) begin
    if (rst) begin
      state         <= S_RELEASED;
      cnt           <= '0;
      switch_level  <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      press_count   <= '0;
    end else begin
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      case (state)
        S_RELEASED: begin
          if (sync) begin
            state <= S_PRESS_WAIT;
            cnt   <= '0;
          end
        end
        S_PRESS_WAIT: begin
          if (!sync) begin
            state <= S_RELEASED;
          end else if (cnt == DB_LAST) begin
            state        <= S_PRESSED;
            switch_level <= 1'b1;
            press_pulse  <= 1'b1;
            press_count  <= press_count + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_PRESSED: begin
          if (!sync) begin
            state <= S_RELEASE_WAIT;
            cnt   <= '0;
          end
        end
        S_RELEASE_WAIT: begin
          if (sync) begin
            state <= S_PRESSED;
          end else if (cnt == DB_LAST) begin
            state         <= S_RELEASED;
            switch_level  <= 1'b0;
            release_pulse <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_RELEASED;
      endcase
    end
  end

`ifdef SWITCH_LONG_PRESS_EN
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] HOLD_MAX  = CW'(LONG_CYC);

  logic [CW-1:0] hold_cnt;
  logic          long_q;

  // Saturating at LONG_CYC guarantees the compare matches only once per press.
  always_ff @(posedge clk_in) begin
    if (rst) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      if (state == S_PRESS_WAIT && sync && cnt == DB_LAST) begin
        hold_cnt <= '0;
      end else if (state == S_PRESSED || state == S_RELEASE_WAIT) begin
        if (hold_cnt == LONG_LAST) long_q <= 1'b1;
        if (hold_cnt != HOLD_MAX) hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

  assign long_pulse = long_q;
`else
  assign long_pulse = 1'b0;
`endif

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce: run-length reference model feeds a queue, negedge monitor compares.
module tb_switch_debounce;

  localparam int SYNC = 2;
  localparam int DB   = 8;
  localparam int LONG = 32;
  localparam int CW   = 2;

  typedef struct packed {
    logic          level;
    logic          press;
    logic          rel;
    logic          lng;
    logic [CW-1:0] count;
  } exp_t;

  logic          clk_in = 1'b0;
  logic          rst = 1'b1;
  logic          switch_raw = 1'b0;
  logic          switch_level, press_pulse, release_pulse, long_pulse;
  logic [CW-1:0] press_count;

  int checks = 0;
  int errors = 0;
  exp_t sb[$];

  switch_debounce #(
    .SYNC_STAGES(SYNC), .DEBOUNCE_CYC(DB), .LONG_CYC(LONG), .COUNT_W(CW)
  ) dut (
    .clk_in        (clk_in),
    .rst           (rst),
    .switch_raw    (switch_raw),
    .switch_level  (switch_level),
    .press_pulse   (press_pulse),
    .release_pulse (release_pulse),
    .long_pulse    (long_pulse),
    .press_count   (press_count)
  );

  always #5 clk_in = ~clk_in;

  // Reference model: the level flips once the synchronised input has disagreed
  // with it for DB+1 consecutive samples; hold time counts edges spent pressed.
  logic m_pipe[SYNC];
  logic m_lvl = 1'b0;
  int   m_run = 0;
  int   m_hold = 0;
  int   m_cnt = 0;

  always @(posedge clk_in) begin
    exp_t e;
    logic s;
    e = '0;
    if (rst) begin
      for (int i = 0; i < SYNC; i++) m_pipe[i] = 1'b0;
      m_lvl = 1'b0; m_run = 0; m_hold = 0; m_cnt = 0;
    end else begin
      s = m_pipe[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) m_pipe[i] = m_pipe[i-1];
      m_pipe[0] = switch_raw;
      if (m_lvl) begin
        m_hold++;
`ifdef SWITCH_LONG_PRESS_EN
        if (m_hold == LONG) e.lng = 1'b1;
`endif
      end
      m_run = (s != m_lvl) ? m_run + 1 : 0;
      if (m_run == DB + 1) begin
        m_lvl = ~m_lvl;
        m_run = 0;
        if (m_lvl) begin
          e.press = 1'b1;
          m_cnt = (m_cnt + 1) % (1 << CW);
          m_hold = 0;
        end else begin
          e.rel = 1'b1;
        end
      end
      e.level = m_lvl;
      e.count = CW'(m_cnt);
    end
    sb.push_back(e);
  end

  task automatic chk(input string name, input int got, input int exp, input int cyc);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0d expected %0d", name, cyc, got, exp);
    end
  endtask

  int cyc = 0;
  always @(negedge clk_in) begin
    exp_t e;
    cyc++;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      chk("switch_level",  int'(switch_level),  int'(e.level), cyc);
      chk("press_pulse",   int'(press_pulse),   int'(e.press), cyc);
      chk("release_pulse", int'(release_pulse), int'(e.rel),   cyc);
      chk("long_pulse",    int'(long_pulse),    int'(e.lng),   cyc);
      chk("press_count",   int'(press_count),   int'(e.count), cyc);
      chk("pulse_overlap", int'(press_pulse & release_pulse), 0, cyc);
    end
  end

  task automatic hold(input logic v, input int n);
    switch_raw = v;
    repeat (n) @(negedge clk_in);
  endtask

  initial begin
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    // clean press, bounce, glitchy release, long press
    hold(0, 5);  hold(1, 20); hold(0, 15);
    hold(1, 5);  hold(0, 3);  hold(1, 20);
    hold(0, 4);  hold(1, 3);  hold(0, 20);
    hold(1, 50); hold(0, 20);
    // reset while qualifying a press, switch still held
    hold(1, 7);
    rst = 1'b1;
    repeat (3) @(negedge clk_in);
    rst = 1'b0;
    hold(1, 20); hold(0, 20);
    // press_count wrap
    repeat (5) begin
      hold(1, 12); hold(0, 12);
    end
    // random bounce patterns with occasional reset
    repeat (200) begin
      if ($urandom_range(0, 40) == 0) begin
        rst = 1'b1;
        repeat ($urandom_range(1, 2)) @(negedge clk_in);
        rst = 1'b0;
      end
      if ($urandom_range(0, 5) == 0) hold(1'($urandom_range(0, 1)), $urandom_range(30, 45));
      else                           hold(1'($urandom_range(0, 1)), $urandom_range(1, 12));
    end
    hold(0, 20);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
